alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports rN_valid  in  1  request valid from requester N (N=0,1).
REQ-005 SHALL have ports rN_ready  out  1  request accepted this cycle (N=0,1).
REQ-006 SHALL have ports rN_a, rN_b  in  32  operands from requester N.
REQ-007 SHALL have ports rN_op  in  4  ALU control code from requester N.
REQ-008 SHALL have ports rN_rsp_valid  out  1  response valid to requester N.
REQ-009 SHALL have ports rN_rsp_ready  in  1  requester N accepts response.
REQ-010 SHALL have port rsp_result  out  32  result, qualified by the active rN_rsp_valid.
REQ-011 SHALL have ports rsp_z / rsp_err  out  1  zero flag / illegal-op flag, qualified likewise.
REQ-012 SHALL have ports alu_a, alu_b  out  32  and alu_ctrl  out  4  driving the shared ALU.
REQ-013 SHALL have ports alu_result  in  32  and alu_z  in  1  from the shared ALU (combinational).
REQ-014 SHALL have port busy  out  1  high when state is not IDLE.
REQ-015 SHALL have port op_count  out  CNT_W  count of completed responses.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; reset state IDLE.
REQ-017 IDLE: grant G = only valid requester; if both valid, G = prio pointer; rG_ready=1 combinationally, other ready=0.
REQ-018 rN_ready SHALL be 0 in EXEC, RESP and while rst=1.
REQ-019 Accept cycle (rG_valid & rG_ready): capture rG_a, rG_b, rG_op, G into registers; next state EXEC.
REQ-020 IDLE with no valid: remain IDLE; no register changes.
REQ-021 alu_a/alu_b/alu_ctrl SHALL be registered, equal captured values from cycle after accept until next accept.
REQ-022 EXEC (one cycle): capture alu_result->rsp_result, alu_z->rsp_z, rsp_err = (captured op > 4'b1001); next RESP.
REQ-023 Latency: accept in cycle T -> rG_rsp_valid high from cycle T+2.
REQ-024 RESP: rG_rsp_valid=1, other rsp_valid=0; rsp_result/z/err held stable until handshake.
REQ-025 RESP handshake (rG_rsp_valid & rG_rsp_ready): prio <= ~G, op_count += 1, next IDLE; earliest next accept is following cycle.
REQ-026 Operand/op changes on any request input before accept SHALL have no effect; only accept-cycle values used.
REQ-027 op_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-028 Illegal op SHALL still be issued to ALU; result passed through unmodified (ALU returns 32'hDEADBEEF).
REQ-029 Both requesters continuously valid with immediate rsp_ready SHALL be served strictly alternately.

Reset
REQ-030 rst=1 SHALL force: state IDLE, prio 0 (r0 preferred), all rN_ready/rN_rsp_valid 0, rsp_result/rsp_z/rsp_err 0, alu_a/alu_b/alu_ctrl 0, busy 0, op_count 0.
REQ-031 rst asserted mid-operation (EXEC or RESP) SHALL discard the pending operation; no response issued after reset.

Verification
REQ-032 r0 only, ADD(0000) a=5 b=7, rsp_ready=1 -> r0_ready in T, r0_rsp_valid in T+2, result 12, z=0, err=0, op_count=1.
REQ-033 Both valid from reset, r0 SUB 3,3 and r1 XOR 0xF0,0x0F held, rsp_ready=1 -> grants r0,r1,r0,r1; r0 result 0 z=1; r1 result 0xFF.
REQ-034 r0 response with r0_rsp_ready low 5 cycles, r1 valid -> r0_rsp_valid held 5+ cycles, result stable, r1_ready stays 0 until the cycle after handshake.
REQ-035 r1 op 4'b1111 -> rsp_result 32'hDEADBEEF, rsp_err=1, rsp_z=0, r1_rsp_valid only.
REQ-036 rst pulsed during EXEC -> no rsp_valid afterwards, busy 0, op_count 0, next simultaneous request granted to r0.
REQ-037 CNT_W=4, 16 completed SRA ops (0x80000000 >>> 4 -> 0xF8000000) -> op_count reads 15 then wraps to 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Two-requester request/response bus for the shared-ALU arbiter.
// Revision    : 1.0
// ============================================================================
interface alu_arbiter_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [3:0]  r0_op;
    logic        r0_rsp_valid;
    logic        r0_rsp_ready;

    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [3:0]  r1_op;
    logic        r1_rsp_valid;
    logic        r1_rsp_ready;

    logic [31:0] rsp_result;
    logic        rsp_z;
    logic        rsp_err;

    modport master (
        output r0_valid, r0_a, r0_b, r0_op, r0_rsp_ready,
        output r1_valid, r1_a, r1_b, r1_op, r1_rsp_ready,
        input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        input  rsp_result, rsp_z, rsp_err
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_op, r0_rsp_ready,
        input  r1_valid, r1_a, r1_b, r1_op, r1_rsp_ready,
        output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        output rsp_result, rsp_z, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters, one operation in flight at a time.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_arbiter_if.slave        bus,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [3:0]          alu_ctrl,
    input  wire logic [31:0]    alu_result,
    input  wire logic           alu_z,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_LEGAL_OP = 4'b1001;

    state_t             r_state;
    logic               r_prio;
    logic               r_gnt;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [3:0]         r_alu_ctrl;
    logic               r_rsp_valid0;
    logic               r_rsp_valid1;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_z;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_idle;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_rsp_hs;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [3:0]         w_op;

    // r1 wins only when it is the sole requester or holds the priority pointer.
    assign w_idle   = (r_state == ST_IDLE) && !rst;
    assign w_gnt1   = bus.r1_valid && (!bus.r0_valid || r_prio);
    assign bus.r0_ready = w_idle && bus.r0_valid && !w_gnt1;
    assign bus.r1_ready = w_idle && w_gnt1;
    assign w_accept = bus.r0_ready || bus.r1_ready;

    assign w_a  = w_gnt1 ? bus.r1_a  : bus.r0_a;
    assign w_b  = w_gnt1 ? bus.r1_b  : bus.r0_b;
    assign w_op = w_gnt1 ? bus.r1_op : bus.r0_op;

    assign w_rsp_hs = (r_rsp_valid0 && bus.r0_rsp_ready) ||
                      (r_rsp_valid1 && bus.r1_rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_prio       <= 1'b0;
            r_gnt        <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_alu_ctrl <= w_op;
                        r_gnt      <= w_gnt1;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Illegal codes still go through the ALU; only the flag marks them.
                    r_rsp_result <= alu_result;
                    r_rsp_z      <= alu_z;
                    r_rsp_err    <= (r_alu_ctrl > c_LAST_LEGAL_OP);
                    r_rsp_valid0 <= !r_gnt;
                    r_rsp_valid1 <= r_gnt;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid0 <= 1'b0;
                        r_rsp_valid1 <= 1'b0;
                        r_prio       <= !r_gnt;
                        r_op_count   <= r_op_count + CNT_W'(1);
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a            = r_alu_a;
    assign alu_b            = r_alu_b;
    assign alu_ctrl         = r_alu_ctrl;
    assign bus.r0_rsp_valid = r_rsp_valid0;
    assign bus.r1_rsp_valid = r_rsp_valid1;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_z        = r_rsp_z;
    assign bus.rsp_err      = r_rsp_err;
    assign busy             = (r_state != ST_IDLE);
    assign op_count         = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter against a transaction model.
// Revision    : 1.0
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_z;
    logic        busy;
    logic [3:0]  op_count;

    alu_arbiter_if bus ();

    alu_arbiter #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Shared ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
    assign alu_z      = (alu_result == 32'd0);

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference: one pending op, its age in cycles, priority.
    bit          m_pend;
    int          m_g;
    int          m_age;
    int          m_prio;
    int          m_cnt;
    logic [31:0] m_res;
    logic [3:0]  m_op;
    logic [31:0] m_alu_a;
    logic [31:0] m_alu_b;
    logic [3:0]  m_alu_ctrl;
    int          grant_log[$];
    logic [31:0] res_log[$];
    int          n_rv0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_g = 0; m_age = 0; m_prio = 0; m_cnt = 0;
        m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0;
    endtask

    task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] op0, input bit v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [3:0] op1,
                        input bit rr0, input bit rr1);
        int g;
        bit resp;
        @(negedge clk);
        bus.r0_valid = v0; bus.r0_a = a0; bus.r0_b = b0; bus.r0_op = op0;
        bus.r1_valid = v1; bus.r1_a = a1; bus.r1_b = b1; bus.r1_op = op1;
        bus.r0_rsp_ready = rr0; bus.r1_rsp_ready = rr1;
        #1;
        g = -1;
        if (!m_pend) begin
            if (v0 && v1) g = m_prio;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        resp = m_pend && (m_age >= 2);
        chk("r0_ready", 32'(bus.r0_ready), 32'(g == 0));
        chk("r1_ready", 32'(bus.r1_ready), 32'(g == 1));
        chk("r0_rsp_valid", 32'(bus.r0_rsp_valid), 32'(resp && m_g == 0));
        chk("r1_rsp_valid", 32'(bus.r1_rsp_valid), 32'(resp && m_g == 1));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("alu_a", alu_a, m_alu_a);
        chk("alu_b", alu_b, m_alu_b);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_alu_ctrl));
        if (resp) begin
            chk("rsp_result", bus.rsp_result, m_res);
            chk("rsp_z", 32'(bus.rsp_z), 32'(m_res == 32'd0));
            chk("rsp_err", 32'(bus.rsp_err), 32'(m_op > 4'd9));
        end
        if (bus.r0_rsp_valid) n_rv0++;
        @(posedge clk);
        if (g >= 0) begin
            m_pend = 1; m_g = g; m_age = 1;
            m_alu_a    = (g == 1) ? a1 : a0;
            m_alu_b    = (g == 1) ? b1 : b0;
            m_alu_ctrl = (g == 1) ? op1 : op0;
            m_op  = m_alu_ctrl;
            m_res = alu_f(m_alu_a, m_alu_b, m_alu_ctrl);
            grant_log.push_back(g);
        end else if (m_pend) begin
            if (resp && ((m_g == 1) ? rr1 : rr0)) begin
                m_pend = 0;
                m_cnt  = (m_cnt + 1) % 16;
                m_prio = (m_g == 0) ? 1 : 0;
                res_log.push_back(m_res);
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic do_reset(input bit v0, input bit v1);
        @(negedge clk);
        rst = 1'b1;
        bus.r0_valid = v0; bus.r1_valid = v1;
        bus.r0_rsp_ready = 1'b0; bus.r1_rsp_ready = 1'b0;
        #1;
        chk("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(bus.r1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_r0_rsp_valid", 32'(bus.r0_rsp_valid), 32'd0);
        chk("rst_r1_rsp_valid", 32'(bus.r1_rsp_valid), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_z_err", {30'd0, bus.rsp_z, bus.rsp_err}, 32'd0);
        chk("rst_alu", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.r0_valid = 0; bus.r0_a = 0; bus.r0_b = 0; bus.r0_op = 0; bus.r0_rsp_ready = 0;
        bus.r1_valid = 0; bus.r1_a = 0; bus.r1_b = 0; bus.r1_op = 0; bus.r1_rsp_ready = 0;
        model_reset();
        n_rv0 = 0;
        do_reset(1, 1);

        // Single ADD from r0
        step(1, 5, 7, 4'd0, 0, 0, 0, 0, 1, 1);
        idle(3);
        chk("add_result", res_log[$], 32'd12);
        chk("add_count", 32'(op_count), 32'd1);

        // Both valid, held: strict alternation
        do_reset(0, 0);
        grant_log.delete(); res_log.delete();
        for (int i = 0; i < 12; i++)
            step(1, 3, 3, 4'd1, 1, 32'hF0, 32'h0F, 4'd4, 1, 1);
        idle(2);
        chk("alt_n", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("alt_grant", 32'(grant_log[i]), 32'(i % 2));
        chk("alt_res0", res_log[0], 32'd0);
        chk("alt_res1", res_log[1], 32'hFF);

        // Response back-pressure with r1 waiting
        n_rv0 = 0;
        step(1, 100, 23, 4'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 9, 4, 4'd1, 0, 1);
        step(0, 0, 0, 0, 1, 9, 4, 4'd1, 1, 1);
        step(0, 0, 0, 0, 1, 9, 4, 4'd1, 1, 1);
        idle(3);
        chk("hold_cycles", 32'(n_rv0 >= 5), 32'd1);
        chk("hold_r1_after", 32'(grant_log[$]), 32'd1);

        // Illegal op from r1
        step(0, 0, 0, 0, 1, 32'h1234, 32'h5678, 4'hF, 1, 1);
        idle(3);
        chk("illegal_result", res_log[$], 32'hDEADBEEF);

        // Reset during EXEC discards the op; priority returns to r0
        step(0, 0, 0, 0, 1, 1, 2, 4'd0, 1, 1);
        do_reset(0, 0);
        idle(4);
        grant_log.delete();
        step(1, 1, 1, 4'd0, 1, 2, 2, 4'd0, 1, 1);
        chk("post_rst_grant", 32'(grant_log[0]), 32'd0);
        idle(3);

        // 16 SRA ops on a 4-bit counter: 15 then wrap to 0
        do_reset(0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h80000000, 4, 4'd7, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            #2;
            chk("sra_result", res_log[$], 32'hF8000000);
            chk("wrap_count", 32'(op_count), 32'((i + 1) % 16));
        end

        // Randomized traffic, operands churn every cycle
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
